// File: rtl/serial_fadder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_fadder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Width of the bit counter; counts 0..w-1, never wraps.
  function automatic int unsigned count_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fadder_cell.sv
// Combinational one-bit full adder.
module fadder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum is the parity of the inputs; carry is their majority.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_fadder.sv
// Bit-serial adder: one operand bit pair per clock, LSB first, carry kept
// in a register; presents the full word and carry-out on completion.
module serial_fadder
  import serial_fadder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             cin_i,
  input  logic             bit_valid_i,
  input  logic             a_i,
  input  logic             b_i,
  output logic             sum_o,
  output logic             sum_valid_o,
  output logic [WIDTH-1:0] word_o,
  output logic             cout_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int unsigned CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic             carry;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic             cell_sum;
  logic             cell_cout;

  fadder_cell u_cell (
    .a    (a_i),
    .b    (b_i),
    .cin  (carry),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  // New sum bit enters at the MSB so the first bit reaches bit 0 after WIDTH shifts.
  always_comb begin
    shifted = {cell_sum, shreg[WIDTH-1:1]};
  end

  // Control FSM plus datapath registers; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      carry       <= 1'b0;
      count       <= '0;
      shreg       <= '0;
      sum_o       <= 1'b0;
      sum_valid_o <= 1'b0;
      word_o      <= '0;
      cout_o      <= 1'b0;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      sum_valid_o <= 1'b0;
      done_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            carry  <= cin_i;
            count  <= '0;
            shreg  <= '0;
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (bit_valid_i) begin
            sum_o       <= cell_sum;
            sum_valid_o <= 1'b1;
            carry       <= cell_cout;
            shreg       <= shifted;
            if (count == LAST) begin
              word_o <= shifted;
              cout_o <= cell_cout;
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= IDLE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_fadder.sv
// Self-checking bench for serial_fadder at WIDTH=4.
module tb_serial_fadder;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         cin_i = 1'b0;
  logic         bit_valid_i = 1'b0;
  logic         a_i = 1'b0;
  logic         b_i = 1'b0;
  logic         sum_o;
  logic         sum_valid_o;
  logic [W-1:0] word_o;
  logic         cout_o;
  logic         done_o;
  logic         busy_o;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] prev_word = '0;
  logic         prev_cout = 1'b0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    int           bub_after;
    int           nbub;
    int           mid_start;
    logic [W-1:0] exp_word;
    logic         exp_cout;
  } vec_t;

  vec_t tbl[4];

  serial_fadder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .cin_i       (cin_i),
    .bit_valid_i (bit_valid_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .sum_o       (sum_o),
    .sum_valid_o (sum_valid_o),
    .word_o      (word_o),
    .cout_o      (cout_o),
    .done_o      (done_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer addition of the whole words.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output logic [W-1:0] w, output logic c);
    logic [W:0] tot;
    tot = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    w = tot[W-1:0];
    c = tot[W];
  endtask

  task automatic run_op(input vec_t v, input string tag);
    @(negedge clk);
    start_i = 1'b1; cin_i = v.cin; bit_valid_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " busy_after_start"}, 32'(busy_o), 32'd1);
    check({tag, " sv_after_start"}, 32'(sum_valid_o), 32'd0);
    check({tag, " done_single_pulse"}, 32'(done_o), 32'd0);
    for (int i = 0; i < int'(W); i++) begin
      if (i == v.bub_after + 1) begin
        for (int k = 0; k < v.nbub; k++) begin
          @(negedge clk);
          start_i = 1'b0; bit_valid_i = 1'b0;
          @(posedge clk); #1;
          check({tag, " sv_bubble"}, 32'(sum_valid_o), 32'd0);
          check({tag, " done_bubble"}, 32'(done_o), 32'd0);
          check({tag, " busy_bubble"}, 32'(busy_o), 32'd1);
        end
      end
      @(negedge clk);
      bit_valid_i = 1'b1;
      a_i = v.a[i];
      b_i = v.b[i];
      start_i = (i == v.mid_start);
      cin_i = (i == v.mid_start) ? 1'b1 : v.cin;
      @(posedge clk); #1;
      check($sformatf("%s sv_bit%0d", tag, i), 32'(sum_valid_o), 32'd1);
      check($sformatf("%s sum_bit%0d", tag, i), 32'(sum_o), 32'(v.exp_word[i]));
      if (i == int'(W) - 1) begin
        check({tag, " done"}, 32'(done_o), 32'd1);
        check({tag, " word"}, 32'(word_o), 32'(v.exp_word));
        check({tag, " cout"}, 32'(cout_o), 32'(v.exp_cout));
        check({tag, " busy_end"}, 32'(busy_o), 32'd0);
        prev_word = v.exp_word;
        prev_cout = v.exp_cout;
      end else begin
        check({tag, " done_early"}, 32'(done_o), 32'd0);
        check({tag, " busy_mid"}, 32'(busy_o), 32'd1);
        check({tag, " word_hold"}, 32'(word_o), 32'(prev_word));
        check({tag, " cout_hold"}, 32'(cout_o), 32'(prev_cout));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " sum_o"}, 32'(sum_o), 32'd0);
    check({tag, " sum_valid_o"}, 32'(sum_valid_o), 32'd0);
    check({tag, " word_o"}, 32'(word_o), 32'd0);
    check({tag, " cout_o"}, 32'(cout_o), 32'd0);
    check({tag, " done_o"}, 32'(done_o), 32'd0);
    check({tag, " busy_o"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    vec_t v;
    // a, b, cin, bub_after, nbub, mid_start, exp_word, exp_cout
    tbl[0] = '{4'b1011, 4'b0110, 1'b0, -1, 0, -1, 4'b0001, 1'b1};
    tbl[1] = '{4'hF,    4'h0,    1'b1, -1, 0, -1, 4'h0,    1'b1};
    tbl[2] = '{4'b1011, 4'b0110, 1'b0,  1, 2, -1, 4'b0001, 1'b1};
    tbl[3] = '{4'b1011, 4'b0110, 1'b0, -1, 0,  2, 4'b0001, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: each op after the first starts in the previous done cycle.
    for (int n = 0; n < 4; n++) begin
      run_op(tbl[n], $sformatf("tbl%0d", n));
    end

    // bit_valid_i is ignored while idle.
    @(negedge clk);
    start_i = 1'b0; bit_valid_i = 1'b1; a_i = 1'b1; b_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("idle sv", 32'(sum_valid_o), 32'd0);
      check("idle busy", 32'(busy_o), 32'd0);
      check("idle word_hold", 32'(word_o), 32'(prev_word));
    end

    // Asynchronous abort after two bits.
    @(negedge clk);
    start_i = 1'b1; cin_i = 1'b0; bit_valid_i = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start_i = 1'b0; bit_valid_i = 1'b1; a_i = 1'b1; b_i = 1'b0;
      @(posedge clk); #1;
    end
    check("abort pre sum_o", 32'(sum_o), 32'd1);
    check("abort pre busy", 32'(busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    bit_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_word = '0;
    prev_cout = 1'b0;
    v = '{4'h3, 4'h1, 1'b0, -1, 0, -1, 4'h4, 1'b0};
    run_op(v, "post_reset");

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 30; n++) begin
      v.a = W'($urandom);
      v.b = W'($urandom);
      v.cin = 1'($urandom);
      v.bub_after = int'($urandom_range(0, W - 2));
      v.nbub = int'($urandom_range(0, 2));
      v.mid_start = int'($urandom_range(0, W));
      model(v.a, v.b, v.cin, v.exp_word, v.exp_cout);
      run_op(v, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        bit_valid_i = 1'b0; start_i = 1'b0;
        @(posedge clk); #1;
        check($sformatf("rnd%0d gap_done", n), 32'(done_o), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
